// File: rtl/bubbledrive8_pkg.sv
// Shared definitions for the BubbleDrive8 power monitor.
// Holds the FSM encoding, the default timing constants and a saturating counter helper.
package bubbledrive8_pkg;

    typedef enum logic {
        PWRMON_INIT = 1'b0,
        PWRMON_RUN  = 1'b1
    } pwrmon_state_t;

    localparam int PWRMON_DEBOUNCE_DEF = 48000;
    localparam int PWRMON_STARTUP_DEF  = 480000;
    localparam int PWRMON_CNT_W        = 20;

    // Counters stop at all-ones rather than wrapping back to zero.
    function automatic logic [PWRMON_CNT_W-1:0] sat_inc(input logic [PWRMON_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/bubbledrive8_pwrmon_if.sv
// Status bus between the raw board pins, the power monitor and the mode controller.
// GLITCHCNT exists only when BUBBLEDRIVE8_PWRMON_GLITCHCNT_EN is defined.
interface bubbledrive8_pwrmon_if;

    logic PWRSTAT;
    logic MRST;
    logic PWRSTAT_S;
    logic MRST_S;
    logic nSTATVALID;
    logic STATCHG;
`ifdef BUBBLEDRIVE8_PWRMON_GLITCHCNT_EN
    logic [7:0] GLITCHCNT;

    modport master (
        output PWRSTAT,
        output MRST,
        input  PWRSTAT_S,
        input  MRST_S,
        input  nSTATVALID,
        input  STATCHG,
        input  GLITCHCNT
    );

    modport slave (
        input  PWRSTAT,
        input  MRST,
        output PWRSTAT_S,
        output MRST_S,
        output nSTATVALID,
        output STATCHG,
        output GLITCHCNT
    );
`else
    modport master (
        output PWRSTAT,
        output MRST,
        input  PWRSTAT_S,
        input  MRST_S,
        input  nSTATVALID,
        input  STATCHG
    );

    modport slave (
        input  PWRSTAT,
        input  MRST,
        output PWRSTAT_S,
        output MRST_S,
        output nSTATVALID,
        output STATCHG
    );
`endif

endinterface

// File: rtl/bubbledrive8_debouncer.sv
// Two-flop synchronizer plus debounce counter and stable register for one status pin.
// The parent FSM loads the stable value at the end of startup and enables debouncing afterwards.
module bubbledrive8_debouncer
    import bubbledrive8_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = PWRMON_DEBOUNCE_DEF,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic enable,
    input  logic load,
    output logic sync1,
    output logic sync2,
    output logic stable,
    output logic update,
    output logic reject
);

    localparam logic [PWRMON_CNT_W-1:0] DEBOUNCE_TERM = PWRMON_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [PWRMON_CNT_W-1:0] count;
    logic                    mismatch;
    logic                    terminal;

    assign mismatch = (sync2 != stable);
    assign terminal = (count == DEBOUNCE_TERM);
    assign update   = enable && mismatch && terminal;
    // A nonzero count falling back to zero without an update is a rejected glitch.
    assign reject   = enable && !mismatch && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= RESET_VAL;
            count  <= '0;
        end else if (load) begin
            stable <= sync2;
            count  <= '0;
        end else if (update) begin
            stable <= sync2;
            count  <= '0;
        end else if (enable && mismatch) begin
            count  <= sat_inc(count);
        end else begin
            count  <= '0;
        end
    end

endmodule

// File: rtl/bubbledrive8_pwrmon.sv
// Power-status conditioner feeding the BubbleDrive8 mode controller: sync, startup settle, debounce.
// Define BUBBLEDRIVE8_PWRMON_GLITCHCNT_EN to add the saturating GLITCHCNT rejected-glitch counter.
module bubbledrive8_pwrmon
    import bubbledrive8_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PWRMON_DEBOUNCE_DEF,
    parameter int STARTUP_CYCLES  = PWRMON_STARTUP_DEF
) (
    input logic                  MCLK,
    input logic                  nRESET,
    bubbledrive8_pwrmon_if.slave bus
);

    localparam logic [PWRMON_CNT_W-1:0] STARTUP_TERM = PWRMON_CNT_W'(STARTUP_CYCLES - 1);

    pwrmon_state_t           state;
    pwrmon_state_t           state_next;
    logic [PWRMON_CNT_W-1:0] startup_cnt;
    logic                    load;
    logic                    enable;
    logic                    sync_moving;
    logic                    statchg;

    logic pwr_sync1, pwr_sync2, pwr_stable, pwr_update, pwr_reject;
    logic mrst_sync1, mrst_sync2, mrst_stable, mrst_update, mrst_reject;

    // PWRSTAT resets to 0 and MRST to 1 so the idle outputs read as the safe PCB-fault code.
    bubbledrive8_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b0)
    ) u_pwrstat (
        .clk   (MCLK),
        .rst_n (nRESET),
        .raw   (bus.PWRSTAT),
        .enable(enable),
        .load  (load),
        .sync1 (pwr_sync1),
        .sync2 (pwr_sync2),
        .stable(pwr_stable),
        .update(pwr_update),
        .reject(pwr_reject)
    );

    bubbledrive8_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b1)
    ) u_mrst (
        .clk   (MCLK),
        .rst_n (nRESET),
        .raw   (bus.MRST),
        .enable(enable),
        .load  (load),
        .sync1 (mrst_sync1),
        .sync2 (mrst_sync2),
        .stable(mrst_stable),
        .update(mrst_update),
        .reject(mrst_reject)
    );

    // True on an edge where either sync2 takes a new value, so the quiet count restarts with it.
    assign sync_moving = (pwr_sync1 != pwr_sync2) || (mrst_sync1 != mrst_sync2);

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= PWRMON_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        enable     = 1'b0;
        case (state)
            PWRMON_INIT: begin
                if (!sync_moving && (startup_cnt == STARTUP_TERM)) begin
                    state_next = PWRMON_RUN;
                    load       = 1'b1;
                end
            end
            PWRMON_RUN: begin
                enable = 1'b1;
            end
            default: begin
                state_next = PWRMON_INIT;
            end
        endcase
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            startup_cnt <= '0;
        end else if ((state != PWRMON_INIT) || sync_moving || (startup_cnt == STARTUP_TERM)) begin
            startup_cnt <= '0;
        end else begin
            startup_cnt <= sat_inc(startup_cnt);
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            statchg <= 1'b0;
        end else begin
            statchg <= pwr_update | mrst_update;
        end
    end

    assign bus.PWRSTAT_S  = pwr_stable;
    assign bus.MRST_S     = mrst_stable;
    assign bus.nSTATVALID = (state == PWRMON_INIT);
    assign bus.STATCHG    = statchg;

`ifdef BUBBLEDRIVE8_PWRMON_GLITCHCNT_EN
    logic [7:0] glitch_cnt;
    logic [8:0] glitch_sum;

    assign glitch_sum = {1'b0, glitch_cnt} + {8'd0, pwr_reject} + {8'd0, mrst_reject};

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            glitch_cnt <= '0;
        end else if (state == PWRMON_RUN) begin
            glitch_cnt <= glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
        end
    end

    assign bus.GLITCHCNT = glitch_cnt;
`else
    logic glitch_unused;
    assign glitch_unused = pwr_reject | mrst_reject;
`endif

endmodule

// File: tb/tb_bubbledrive8_pwrmon.sv
// Self-checking bench for bubbledrive8_pwrmon (DEBOUNCE_CYCLES = 8, STARTUP_CYCLES = 16).
// A window-based reference model derives every expected output from the sampled input history.
module tb_bubbledrive8_pwrmon;

    localparam int DB = 8;
    localparam int ST = 16;
    localparam int N  = 8192;

    logic MCLK   = 1'b0;
    logic nRESET = 1'b0;

    bubbledrive8_pwrmon_if bus();

    bubbledrive8_pwrmon #(
        .DEBOUNCE_CYCLES(DB),
        .STARTUP_CYCLES (ST)
    ) dut (
        .MCLK  (MCLK),
        .nRESET(nRESET),
        .bus   (bus.slave)
    );

    always #5 MCLK = ~MCLK;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   edge_num;
    logic s2p [N];
    logic s2m [N];
    logic prev_raw_p, prev_raw_m;
    logic model_valid;
    int   model_valid_edge;
    int   last_upd_p, last_upd_m;
    logic exp_p, exp_m, exp_chg;
    int   exp_glitch;
    int   valid_seen;
    logic checking = 1'b0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, actual, expected, edge_num);
        end
    endtask

    function automatic logic s2At(input bit is_m, input int idx);
        return is_m ? s2m[idx] : s2p[idx];
    endfunction

    // Both synchronized inputs constant over the last STARTUP_CYCLES+1 samples (index 0 = reset value).
    function automatic bit quietWindow(input int e);
        for (int i = e - ST; i < e; i++) begin
            if (s2p[i] != s2p[e] || s2m[i] != s2m[e]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // New level accepted when the DB samples before this edge, all newer than the last update, disagree with the output.
    function automatic bit heldNew(input bit is_m, input int e, input logic st, input int lup);
        if (e - DB < lup) return 1'b0;
        for (int i = e - DB; i < e; i++) begin
            if (s2At(is_m, i) == st) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit rejected(input bit is_m, input int e, input logic st, input int lup);
        if (e - 2 < lup) return 1'b0;
        return (s2At(is_m, e - 2) != st) && (s2At(is_m, e - 1) == st);
    endfunction

    task automatic modelReset();
        edge_num         = 0;
        s2p[0]           = 1'b0;
        s2m[0]           = 1'b1;
        prev_raw_p       = 1'b0;
        prev_raw_m       = 1'b1;
        model_valid      = 1'b0;
        model_valid_edge = -1;
        last_upd_p       = 0;
        last_upd_m       = 0;
        exp_p            = 1'b0;
        exp_m            = 1'b1;
        exp_chg          = 1'b0;
        exp_glitch       = 0;
    endtask

    task automatic modelStep();
        bit upd_p, upd_m, rej_p, rej_m;
        if (edge_num >= N - 1) return;
        edge_num++;
        s2p[edge_num] = prev_raw_p;
        s2m[edge_num] = prev_raw_m;
        prev_raw_p    = bus.PWRSTAT;
        prev_raw_m    = bus.MRST;
        exp_chg       = 1'b0;
        if (!model_valid) begin
            if (edge_num >= ST && quietWindow(edge_num)) begin
                model_valid      = 1'b1;
                model_valid_edge = edge_num;
                exp_p            = s2p[edge_num];
                exp_m            = s2m[edge_num];
                last_upd_p       = edge_num;
                last_upd_m       = edge_num;
            end
        end else begin
            upd_p = heldNew(1'b0, edge_num, exp_p, last_upd_p);
            upd_m = heldNew(1'b1, edge_num, exp_m, last_upd_m);
            rej_p = rejected(1'b0, edge_num, exp_p, last_upd_p);
            rej_m = rejected(1'b1, edge_num, exp_m, last_upd_m);
            if (upd_p) begin
                exp_p      = ~exp_p;
                last_upd_p = edge_num;
            end
            if (upd_m) begin
                exp_m      = ~exp_m;
                last_upd_m = edge_num;
            end
            exp_chg    = upd_p | upd_m;
            exp_glitch = exp_glitch + int'(rej_p) + int'(rej_m);
            if (exp_glitch > 255) exp_glitch = 255;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge MCLK or negedge nRESET);
            if (!nRESET) modelReset();
            else modelStep();
        end
    end

    always @(negedge MCLK) begin
        if (checking && nRESET) begin
            checkOutput("PWRSTAT_S", int'(bus.PWRSTAT_S), int'(exp_p));
            checkOutput("MRST_S", int'(bus.MRST_S), int'(exp_m));
            checkOutput("nSTATVALID", int'(bus.nSTATVALID), int'(!model_valid));
            checkOutput("STATCHG", int'(bus.STATCHG), int'(exp_chg));
`ifdef BUBBLEDRIVE8_PWRMON_GLITCHCNT_EN
            checkOutput("GLITCHCNT", int'(bus.GLITCHCNT), exp_glitch);
`endif
            if (bus.nSTATVALID === 1'b0 && valid_seen < 0) valid_seen = edge_num;
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_PWRSTAT_S"}, int'(bus.PWRSTAT_S), 0);
        checkOutput({tag, "_MRST_S"}, int'(bus.MRST_S), 1);
        checkOutput({tag, "_nSTATVALID"}, int'(bus.nSTATVALID), 1);
        checkOutput({tag, "_STATCHG"}, int'(bus.STATCHG), 0);
`ifdef BUBBLEDRIVE8_PWRMON_GLITCHCNT_EN
        checkOutput({tag, "_GLITCHCNT"}, int'(bus.GLITCHCNT), 0);
`endif
    endtask

    task automatic applyStimulus(input logic p, input logic m, input int cycles);
        bus.PWRSTAT = p;
        bus.MRST    = m;
        repeat (cycles) @(negedge MCLK);
    endtask

    task automatic doReset(input logic p, input logic m);
        nRESET      = 1'b0;
        bus.PWRSTAT = p;
        bus.MRST    = m;
        repeat (3) @(negedge MCLK);
        checkResetValues("reset");
        valid_seen = -1;
        nRESET     = 1'b1;
    endtask

    initial begin
        bus.PWRSTAT = 1'b1;
        bus.MRST    = 1'b1;
        valid_seen  = -1;
        @(negedge MCLK);
        checking = 1'b1;

        // Steady inputs: valid after the sync delay plus the full window.
        doReset(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 30);
        checkOutput("startup_edge", valid_seen, 18);

        // PWRSTAT bouncing during startup keeps restarting the window.
        doReset(1'b0, 1'b1);
        for (int k = 0; k < 6; k++) applyStimulus(logic'(k % 2 == 0), 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 40);
        checkOutput("bounce_valid_edge", valid_seen, model_valid_edge);
        checkOutput("bounce_valid_late", int'(valid_seen > 60), 1);

        // Held change, short glitch, exact-length glitch, simultaneous change.
        applyStimulus(1'b0, 1'b0, 20);
        applyStimulus(1'b0, 1'b1, 7);
        applyStimulus(1'b0, 1'b0, 20);
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 20);

        for (int i = 0; i < 120; i++) begin
            applyStimulus(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                          int'($urandom_range(1, 12)));
        end

        // Reset in the middle of a debounce count.
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 4);
        @(posedge MCLK);
        #2 nRESET = 1'b0;
        #1 checkResetValues("midrun");
        @(negedge MCLK);
        valid_seen = -1;
        nRESET     = 1'b1;
        applyStimulus(1'b1, 1'b1, 30);
        checkOutput("restart_edge", valid_seen, 18);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
